// File: rtl/mem_axi_arb_pkg.sv
// mem_axi_arb_pkg
// Shared definitions for the AXI memory port arbiter:
//   - arb_state_e      : arbiter FSM state encoding
//   - AXI_* constants  : response / burst / length encodings
//   - axi_size()       : AXI AxSIZE value for a given data bus width
// The AXI len/size/burst fields are constant for this single-beat master
// and are driven from these definitions by the wrapper around the arbiter.
package mem_axi_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_RESP = 3'd4,
        ST_RESP    = 3'd5
    } arb_state_e;

    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;

    // AxSIZE = log2(bytes per beat)
    function automatic logic [2:0] axi_size(input int unsigned data_width);
        return 3'($clog2(data_width / 8));
    endfunction

endpackage

// File: rtl/mem_axi_rr_pick.sv
// mem_axi_rr_pick
// Combinational round-robin picker. Searches the request vector starting
// at ptr+1 (wrapping) and reports the first asserted request.
// Ports:
//   req    in  NumPorts  request vector
//   ptr    in  PtrW      index of the last winner
//   valid  out 1         at least one request present
//   idx    out PtrW      winner index
//   onehot out NumPorts  winner as one-hot (all zero when !valid)
module mem_axi_rr_pick
    import mem_axi_arb_pkg::*;
#(
    parameter int NumPorts = 4,
    parameter int PtrW     = $clog2(NumPorts)
) (
    input  logic [NumPorts-1:0] req,
    input  logic [PtrW-1:0]     ptr,
    output logic                valid,
    output logic [PtrW-1:0]     idx,
    output logic [NumPorts-1:0] onehot
);

    int              cand;
    logic [PtrW-1:0] cand_idx;

    always_comb begin
        valid    = 1'b0;
        idx      = '0;
        onehot   = '0;
        cand     = 0;
        cand_idx = '0;
        // i runs 1..NumPorts so the previous winner is considered last
        for (int i = 1; i <= NumPorts; i++) begin
            cand = int'(ptr) + i;
            if (cand >= NumPorts) begin
                cand = cand - NumPorts;
            end
            cand_idx = PtrW'(cand);
            if (!valid && req[cand_idx]) begin
                valid = 1'b1;
                idx   = cand_idx;
            end
        end
        onehot[idx] = valid;
    end

endmodule

// File: rtl/mem_axi_port_arbiter.sv
// mem_axi_port_arbiter
// Shares one AXI4 master port between NumPorts single-beat req/gnt/rvalid
// requesters. Round-robin arbitration, one outstanding transaction at a time.
// Each grant becomes one single-beat AXI write (AW+W then B) or read (AR then R),
// followed by a one-cycle rvalid pulse to the granted port.
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   port_req/we/addr/be/wdata_i  per-port request bundle (flattened)
//   port_gnt_o                   one-hot grant, combinational, IDLE only
//   port_rvalid_o/rdata_o/err_o  response pulse, shared read data, error
//   aw_*, w_*, b_*, ar_*, r_*    AXI4 master channels (single beat)
//   stat_txn_o, stat_stall_o     only with MEM_AXI_ARB_STATS_EN defined
//   dbg_state_o                  current FSM state (arb_state_e encoding)
// Handshake: every AXI valid is held until its ready is seen; a channel
// transfer happens on a cycle where valid and ready are both high. B and R
// are only accepted (ready=1) in WR_RESP / RD_RESP respectively.
// Optional feature macro: MEM_AXI_ARB_STATS_EN.
module mem_axi_port_arbiter
    import mem_axi_arb_pkg::*;
#(
    parameter int NumPorts  = 4,
    parameter int AddrWidth = 64,
    parameter int DataWidth = 64,
    parameter int IdWidth   = 8
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NumPorts-1:0]             port_req_i,
    output logic [NumPorts-1:0]             port_gnt_o,
    input  logic [NumPorts-1:0]             port_we_i,
    input  logic [NumPorts*AddrWidth-1:0]   port_addr_i,
    input  logic [NumPorts*DataWidth/8-1:0] port_be_i,
    input  logic [NumPorts*DataWidth-1:0]   port_wdata_i,
    output logic [NumPorts-1:0]             port_rvalid_o,
    output logic [DataWidth-1:0]            port_rdata_o,
    output logic                            port_err_o,
    output logic                            aw_valid_o,
    input  logic                            aw_ready_i,
    output logic [AddrWidth-1:0]            aw_addr_o,
    output logic [IdWidth-1:0]              aw_id_o,
    output logic                            w_valid_o,
    input  logic                            w_ready_i,
    output logic [DataWidth-1:0]            w_data_o,
    output logic [DataWidth/8-1:0]          w_strb_o,
    output logic                            w_last_o,
    input  logic                            b_valid_i,
    output logic                            b_ready_o,
    input  logic [1:0]                      b_resp_i,
    output logic                            ar_valid_o,
    input  logic                            ar_ready_i,
    output logic [AddrWidth-1:0]            ar_addr_o,
    output logic [IdWidth-1:0]              ar_id_o,
    input  logic                            r_valid_i,
    output logic                            r_ready_o,
    input  logic [DataWidth-1:0]            r_data_i,
    input  logic [1:0]                      r_resp_i,
    input  logic                            r_last_i,
`ifdef MEM_AXI_ARB_STATS_EN
    output logic [31:0]                     stat_txn_o,
    output logic [31:0]                     stat_stall_o,
`endif
    output logic [2:0]                      dbg_state_o
);

    localparam int PtrW  = $clog2(NumPorts);
    localparam int StrbW = DataWidth / 8;

    arb_state_e           state_q, state_d;
    logic [PtrW-1:0]      ptr_q, idx_q;
    logic [AddrWidth-1:0] addr_q;
    logic [StrbW-1:0]     be_q;
    logic [DataWidth-1:0] wdata_q, rdata_q;
    logic                 err_q;
    logic                 aw_done_q, w_done_q;

    logic                 pick_valid;
    logic [PtrW-1:0]      pick_idx;
    logic [NumPorts-1:0]  pick_onehot;
    logic                 grant_fire;
    logic                 aw_valid, w_valid, b_ready, ar_valid, r_ready;
    logic [NumPorts-1:0]  rvalid;

    // Single-beat only: R last carries no information here.
    logic unused_r_last;
    assign unused_r_last = r_last_i;

    mem_axi_rr_pick #(.NumPorts(NumPorts), .PtrW(PtrW)) u_pick (
        .req    (port_req_i),
        .ptr    (ptr_q),
        .valid  (pick_valid),
        .idx    (pick_idx),
        .onehot (pick_onehot)
    );

    assign grant_fire = (state_q == ST_IDLE) && pick_valid;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            ptr_q     <= PtrW'(NumPorts - 1);
            idx_q     <= '0;
            addr_q    <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (grant_fire) begin
                ptr_q     <= pick_idx;
                idx_q     <= pick_idx;
                addr_q    <= port_addr_i[int'(pick_idx)*AddrWidth +: AddrWidth];
                be_q      <= port_be_i[int'(pick_idx)*StrbW +: StrbW];
                wdata_q   <= port_wdata_i[int'(pick_idx)*DataWidth +: DataWidth];
                rdata_q   <= '0;
                err_q     <= 1'b0;
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
            end
            // AW and W complete independently; remember each until both are done.
            if (aw_valid && aw_ready_i) begin
                aw_done_q <= 1'b1;
            end
            if (w_valid && w_ready_i) begin
                w_done_q <= 1'b1;
            end
            if (b_ready && b_valid_i) begin
                err_q <= (b_resp_i != AXI_RESP_OKAY);
            end
            if (r_ready && r_valid_i) begin
                rdata_q <= r_data_i;
                err_q   <= (r_resp_i != AXI_RESP_OKAY);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        aw_valid = 1'b0;
        w_valid  = 1'b0;
        b_ready  = 1'b0;
        ar_valid = 1'b0;
        r_ready  = 1'b0;
        rvalid   = '0;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d = port_we_i[pick_idx] ? ST_WR_REQ : ST_RD_REQ;
                end
            end
            ST_WR_REQ: begin
                aw_valid = !aw_done_q;
                w_valid  = !w_done_q;
                if ((aw_done_q || aw_ready_i) && (w_done_q || w_ready_i)) begin
                    state_d = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                b_ready = 1'b1;
                if (b_valid_i) begin
                    state_d = ST_RESP;
                end
            end
            ST_RD_REQ: begin
                ar_valid = 1'b1;
                if (ar_ready_i) begin
                    state_d = ST_RD_RESP;
                end
            end
            ST_RD_RESP: begin
                r_ready = 1'b1;
                if (r_valid_i) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                rvalid[idx_q] = 1'b1;
                state_d       = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A grant issued while reset is asserted would be lost, so suppress it.
    assign port_gnt_o    = (grant_fire && !rst_i) ? pick_onehot : '0;
    assign port_rvalid_o = rvalid;
    assign port_rdata_o  = rdata_q;
    assign port_err_o    = err_q && (state_q == ST_RESP);

    assign aw_valid_o = aw_valid;
    assign aw_addr_o  = addr_q;
    assign aw_id_o    = IdWidth'(idx_q);
    assign w_valid_o  = w_valid;
    assign w_data_o   = wdata_q;
    assign w_strb_o   = be_q;
    assign w_last_o   = 1'b1;
    assign b_ready_o  = b_ready;
    assign ar_valid_o = ar_valid;
    assign ar_addr_o  = addr_q;
    assign ar_id_o    = IdWidth'(idx_q);
    assign r_ready_o  = r_ready;

    assign dbg_state_o = state_q;

`ifdef MEM_AXI_ARB_STATS_EN
    logic        stall;
    logic [31:0] txn_q, stall_q;

    // Stall: a request channel waiting on ready, or a response not yet returned.
    assign stall = ((state_q == ST_WR_REQ) &&
                    ((aw_valid && !aw_ready_i) || (w_valid && !w_ready_i))) ||
                   ((state_q == ST_RD_REQ)  && !ar_ready_i) ||
                   ((state_q == ST_WR_RESP) && !b_valid_i) ||
                   ((state_q == ST_RD_RESP) && !r_valid_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            txn_q   <= '0;
            stall_q <= '0;
        end else begin
            if (state_q == ST_RESP) begin
                txn_q <= txn_q + 32'd1;
            end
            if (stall) begin
                stall_q <= stall_q + 32'd1;
            end
        end
    end

    assign stat_txn_o   = txn_q;
    assign stat_stall_o = stall_q;
`endif

endmodule

// File: tb/tb_mem_axi_port_arbiter.sv
// tb_mem_axi_port_arbiter
// Directed, table-driven bench for mem_axi_port_arbiter (4 ports, 64/64/8).
// Each table row holds the requester/slave inputs for one clock cycle and
// the outputs expected in that cycle. A hand-written sequence afterwards
// covers reset in the middle of a read.
module tb_mem_axi_port_arbiter;
    import mem_axi_arb_pkg::*;

    localparam int N  = 4;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam int IW = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic [N-1:0]        port_req, port_gnt, port_we, port_rvalid;
    logic [N*AW-1:0]     port_addr;
    logic [N*DW/8-1:0]   port_be;
    logic [N*DW-1:0]     port_wdata;
    logic [DW-1:0]       port_rdata;
    logic                port_err;
    logic                aw_valid, aw_ready, w_valid, w_ready, w_last;
    logic [AW-1:0]       aw_addr, ar_addr;
    logic [IW-1:0]       aw_id, ar_id;
    logic [DW-1:0]       w_data, r_data;
    logic [DW/8-1:0]     w_strb;
    logic                b_valid, b_ready, ar_valid, ar_ready, r_valid, r_ready, r_last;
    logic [1:0]          b_resp, r_resp;
    logic [2:0]          dbg_state;
`ifdef MEM_AXI_ARB_STATS_EN
    logic [31:0]         stat_txn, stat_stall;
`endif

    mem_axi_port_arbiter #(.NumPorts(N), .AddrWidth(AW), .DataWidth(DW), .IdWidth(IW)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .port_req_i    (port_req),
        .port_gnt_o    (port_gnt),
        .port_we_i     (port_we),
        .port_addr_i   (port_addr),
        .port_be_i     (port_be),
        .port_wdata_i  (port_wdata),
        .port_rvalid_o (port_rvalid),
        .port_rdata_o  (port_rdata),
        .port_err_o    (port_err),
        .aw_valid_o    (aw_valid),
        .aw_ready_i    (aw_ready),
        .aw_addr_o     (aw_addr),
        .aw_id_o       (aw_id),
        .w_valid_o     (w_valid),
        .w_ready_i     (w_ready),
        .w_data_o      (w_data),
        .w_strb_o      (w_strb),
        .w_last_o      (w_last),
        .b_valid_i     (b_valid),
        .b_ready_o     (b_ready),
        .b_resp_i      (b_resp),
        .ar_valid_o    (ar_valid),
        .ar_ready_i    (ar_ready),
        .ar_addr_o     (ar_addr),
        .ar_id_o       (ar_id),
        .r_valid_i     (r_valid),
        .r_ready_o     (r_ready),
        .r_data_i      (r_data),
        .r_resp_i      (r_resp),
        .r_last_i      (r_last),
`ifdef MEM_AXI_ARB_STATS_EN
        .stat_txn_o    (stat_txn),
        .stat_stall_o  (stat_stall),
`endif
        .dbg_state_o   (dbg_state)
    );

    // ---------------- per-port request payloads ----------------
    logic [AW-1:0]   addr_tab  [N];
    logic [DW-1:0]   wdata_tab [N];
    logic [DW/8-1:0] be_tab    [N];

    // ---------------- vector table ----------------
    typedef struct {
        logic [N-1:0] req;
        logic         wr;
        logic         awr, wrdy, bv;
        logic [1:0]   bresp;
        logic         arr, rv;
        logic [1:0]   rresp;
        logic [DW-1:0] rdat;
        logic [N-1:0] e_gnt;
        logic [N-1:0] e_rv;
        logic [4:0]   e_ctl;   // {aw_valid, w_valid, b_ready, ar_valid, r_ready}
        logic         e_err;
        logic [DW-1:0] e_rdata;
        int           port;
    } vec_t;

    vec_t vecs[$];

    // ---------------- scoreboard ----------------
    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp, input int row);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row=%0d got=%h expected=%h", name, row, act, exp);
        end
    endtask

    function automatic logic [N-1:0] oh(input int p);
        logic [N-1:0] v;
        v    = '0;
        v[p] = 1'b1;
        return v;
    endfunction

    function automatic vec_t mk(input logic [N-1:0] req, input logic wr,
                                input logic awr, input logic wrdy, input logic bv, input logic [1:0] bresp,
                                input logic arr, input logic rv, input logic [1:0] rresp, input logic [DW-1:0] rdat,
                                input logic [N-1:0] e_gnt, input logic [N-1:0] e_rv, input logic [4:0] e_ctl,
                                input logic e_err, input logic [DW-1:0] e_rdata, input int port);
        vec_t v;
        v.req = req;   v.wr = wr;     v.awr = awr;   v.wrdy = wrdy;
        v.bv = bv;     v.bresp = bresp; v.arr = arr; v.rv = rv;
        v.rresp = rresp; v.rdat = rdat; v.e_gnt = e_gnt; v.e_rv = e_rv;
        v.e_ctl = e_ctl; v.e_err = e_err; v.e_rdata = e_rdata; v.port = port;
        return v;
    endfunction

    // Zero-wait read: grant, AR, R, response pulse.
    task automatic push_read(input int p, input logic [N-1:0] req, input logic [DW-1:0] d,
                             input logic [1:0] resp, input logic stray_b);
        vecs.push_back(mk(req, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00, '0, oh(p), '0, 5'b00000, 0, '0, p));
        vecs.push_back(mk(req, 0, 0, 0, stray_b, 2'b00, 1, 0, 2'b00, '0, '0, '0, 5'b00010, 0, '0, p));
        vecs.push_back(mk(req, 0, 0, 0, 0, 2'b00, 0, 1, resp, d, '0, '0, 5'b00001, 0, '0, p));
        vecs.push_back(mk(req, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00, '0, '0, oh(p), 5'b00000, resp != 2'b00, d, p));
    endtask

    // Zero-wait write: grant, AW+W, B, response pulse (rdata reads back 0).
    task automatic push_write(input int p, input logic [N-1:0] req, input logic [1:0] resp);
        vecs.push_back(mk(req, 1, 0, 0, 0, 2'b00, 0, 0, 2'b00, '0, oh(p), '0, 5'b00000, 0, '0, p));
        vecs.push_back(mk(req, 1, 1, 1, 0, 2'b00, 0, 0, 2'b00, '0, '0, '0, 5'b11000, 0, '0, p));
        vecs.push_back(mk(req, 1, 0, 0, 1, resp, 0, 0, 2'b00, '0, '0, '0, 5'b00100, 0, '0, p));
        vecs.push_back(mk(req, 1, 0, 0, 0, 2'b00, 0, 0, 2'b00, '0, '0, oh(p), 5'b00000, resp != 2'b00, '0, p));
    endtask

    // ---------------- driver ----------------
    task automatic drive(input vec_t v);
        port_req = v.req;
        port_we  = v.wr ? {N{1'b1}} : '0;
        aw_ready = v.awr;
        w_ready  = v.wrdy;
        b_valid  = v.bv;
        b_resp   = v.bresp;
        ar_ready = v.arr;
        r_valid  = v.rv;
        r_resp   = v.rresp;
        r_data   = v.rdat;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check_row(input vec_t v, input int row);
        check("gnt", 64'(port_gnt), 64'(v.e_gnt), row);
        check("rvalid", 64'(port_rvalid), 64'(v.e_rv), row);
        check("ctl", 64'({aw_valid, w_valid, b_ready, ar_valid, r_ready}), 64'(v.e_ctl), row);
        if (v.e_rv != '0) begin
            check("err", 64'(port_err), 64'(v.e_err), row);
            check("rdata", port_rdata, v.e_rdata, row);
        end
        if (v.e_ctl[4]) begin
            check("aw_addr", aw_addr, addr_tab[v.port], row);
            check("aw_id", 64'(aw_id), 64'(v.port), row);
        end
        if (v.e_ctl[3]) begin
            check("w_data", w_data, wdata_tab[v.port], row);
            check("w_strb", 64'(w_strb), 64'(be_tab[v.port]), row);
            check("w_last", 64'(w_last), 64'd1, row);
        end
        if (v.e_ctl[1]) begin
            check("ar_addr", ar_addr, addr_tab[v.port], row);
            check("ar_id", 64'(ar_id), 64'(v.port), row);
        end
    endtask

    // ---------------- test ----------------
    initial begin
        addr_tab[0] = 64'h0000_0000_0000_0040;  wdata_tab[0] = 64'h1111_2222_3333_4444;  be_tab[0] = 8'h0F;
        addr_tab[1] = 64'h0000_0000_0000_1000;  wdata_tab[1] = 64'hDEAD_BEEF_CAFE_F00D;  be_tab[1] = 8'hFF;
        addr_tab[2] = 64'h0000_0000_0000_2008;  wdata_tab[2] = 64'h5555_6666_7777_8888;  be_tab[2] = 8'hF0;
        addr_tab[3] = 64'h0000_0000_0000_3003;  wdata_tab[3] = 64'h9999_AAAA_BBBB_CCCC;  be_tab[3] = 8'h3C;
        for (int p = 0; p < N; p++) begin
            port_addr[p*AW +: AW]       = addr_tab[p];
            port_wdata[p*DW +: DW]      = wdata_tab[p];
            port_be[p*(DW/8) +: (DW/8)] = be_tab[p];
        end
        r_last = 1'b1;

        // Round robin from reset: all four request continuously -> 0,1,2,3,0.
        push_read(0, 4'b1111, 64'hA0A0_0000_0000_0000, 2'b00, 1'b0);
        push_read(1, 4'b1111, 64'hA0A0_0000_0000_0001, 2'b00, 1'b0);
        push_read(2, 4'b1111, 64'hA0A0_0000_0000_0002, 2'b00, 1'b0);
        push_read(3, 4'b1111, 64'hA0A0_0000_0000_0003, 2'b00, 1'b0);
        push_read(0, 4'b1111, 64'hA0A0_0000_0000_0004, 2'b00, 1'b0);
        // Single write on port 1, single read on port 2.
        push_write(1, 4'b0010, 2'b00);
        push_read(2, 4'b0100, 64'h0123_4567_89AB_CDEF, 2'b00, 1'b0);
        // SLVERR read on port 3, with a stray B valid that must be ignored.
        push_read(3, 4'b1000, 64'hBAD0_BAD0_BAD0_BAD0, 2'b10, 1'b1);
        // Port 0 write: AW ready at cycle 1, W ready only at cycle 5.
        vecs.push_back(mk(4'b0001, 1, 0, 0, 0, 2'b00, 0, 0, 2'b00, '0, 4'b0001, '0, 5'b00000, 0, '0, 0));
        vecs.push_back(mk(4'b0001, 1, 1, 0, 0, 2'b00, 0, 0, 2'b00, '0, '0, '0, 5'b11000, 0, '0, 0));
        vecs.push_back(mk(4'b0001, 1, 0, 0, 1, 2'b00, 0, 0, 2'b00, '0, '0, '0, 5'b01000, 0, '0, 0));
        vecs.push_back(mk(4'b0001, 1, 0, 0, 0, 2'b00, 0, 0, 2'b00, '0, '0, '0, 5'b01000, 0, '0, 0));
        vecs.push_back(mk(4'b0001, 1, 0, 0, 0, 2'b00, 0, 0, 2'b00, '0, '0, '0, 5'b01000, 0, '0, 0));
        vecs.push_back(mk(4'b0001, 1, 0, 1, 0, 2'b00, 0, 0, 2'b00, '0, '0, '0, 5'b01000, 0, '0, 0));
        vecs.push_back(mk(4'b0001, 1, 0, 0, 1, 2'b00, 0, 0, 2'b00, '0, '0, '0, 5'b00100, 0, '0, 0));
        vecs.push_back(mk(4'b0001, 1, 0, 0, 0, 2'b00, 0, 0, 2'b00, '0, '0, 4'b0001, 5'b00000, 0, '0, 0));
        // After port 0, ports 1 and 2 compete: port 1 wins; B error reported.
        push_write(1, 4'b0110, 2'b11);

        // Reset
        rst = 1'b1;
        drive(mk('0, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00, '0, '0, '0, 5'b00000, 0, '0, 0));
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("rst_gnt", 64'(port_gnt), 64'd0, -1);
        check("rst_rvalid", 64'(port_rvalid), 64'd0, -1);
        check("rst_ctl", 64'({aw_valid, w_valid, b_ready, ar_valid, r_ready}), 64'd0, -1);
        check("rst_err", 64'(port_err), 64'd0, -1);
        check("rst_rdata", port_rdata, 64'd0, -1);
        check("rst_state", 64'(dbg_state), 64'(ST_IDLE), -1);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            #1;
            check_row(vecs[i], i);
            tick();
        end

        // Reset in RD_RESP: read on port 2 (pointer then points at 2).
        drive(mk(4'b0100, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00, '0, '0, '0, 5'b00000, 0, '0, 0));
        #1;
        check("seq_gnt2", 64'(port_gnt), 64'(4'b0100), 100);
        tick();
        ar_ready = 1'b1;
        #1;
        check("seq_arv", 64'(ar_valid), 64'd1, 101);
        tick();
        ar_ready = 1'b0;
        port_req = 4'b1001;
        rst      = 1'b1;
        #1;
        check("seq_rready", 64'(r_ready), 64'd1, 102);
        tick();
        rst = 1'b0;
        #1;
        check("seq_ctl_after_rst", 64'({aw_valid, w_valid, b_ready, ar_valid, r_ready}), 64'd0, 103);
        check("seq_rvalid_after_rst", 64'(port_rvalid), 64'd0, 103);
        check("seq_state_after_rst", 64'(dbg_state), 64'(ST_IDLE), 103);
        check("seq_gnt_after_rst", 64'(port_gnt), 64'(4'b0001), 103);
        tick();
        ar_ready = 1'b1;
        #1;
        check("seq_ar_id0", 64'(ar_id), 64'd0, 104);
        check("seq_ar_addr0", ar_addr, addr_tab[0], 104);
        tick();
        ar_ready = 1'b0;
        port_req = 4'b0000;
        r_valid  = 1'b1;
        r_data   = 64'hFEED_FACE_0000_0001;
        tick();
        r_valid = 1'b0;
        #1;
        check("seq_rvalid0", 64'(port_rvalid), 64'(4'b0001), 105);
        check("seq_rdata0", port_rdata, 64'hFEED_FACE_0000_0001, 105);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
